// File: rtl/reg_wb_arbiter.sv
// Two-source register-file writeback arbiter: load writeback (B) wins ties,
// ALU writeback (A) is granted once it has been denied STARVE_LIMIT times in a row.
module reg_wb_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   input  logic [4:0]            a_reg,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [4:0]            b_reg,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   output logic                  wr_en,
   output logic [4:0]            wr_reg,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [3:0]            starve_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic                  a_grant_s;
   logic                  b_grant_s;
   logic                  a_hs_s;
   logic                  b_hs_s;
   logic [3:0]            starve_q;
   logic [3:0]            starve_d;
   logic                  wr_en_q;
   logic                  wr_en_d;
   logic [4:0]            wr_reg_q;
   logic [4:0]            wr_reg_d;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [DATA_WIDTH-1:0] wr_data_d;

   // Grant selection; readies are held low while reset is asserted
   always_comb begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
      if (!rst_n) begin
         a_grant_s = 1'b0;
         b_grant_s = 1'b0;
      end else if (a_valid && b_valid) begin
         if (starve_q >= LIMIT) begin
            a_grant_s = 1'b1;
         end else begin
            b_grant_s = 1'b1;
         end
      end else if (a_valid) begin
         a_grant_s = 1'b1;
      end else if (b_valid) begin
         b_grant_s = 1'b1;
      end else begin
         a_grant_s = 1'b0;
         b_grant_s = 1'b0;
      end
   end

   assign a_ready = a_grant_s;
   assign b_ready = b_grant_s;
   assign a_hs_s  = a_valid & a_grant_s;
   assign b_hs_s  = b_valid & b_grant_s;

   // Next-state for the starvation counter and the registered write port
   always_comb begin
      starve_d  = starve_q;
      wr_en_d   = 1'b0;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      if (!a_valid || a_hs_s) begin
         starve_d = 4'd0;
      end else if (starve_q < LIMIT) begin
         starve_d = starve_q + 4'd1;
      end else begin
         starve_d = starve_q;
      end
      // Index 0 is accepted but never written
      if (a_hs_s) begin
         wr_en_d   = (a_reg != 5'd0);
         wr_reg_d  = a_reg;
         wr_data_d = a_data;
      end else if (b_hs_s) begin
         wr_en_d   = (b_reg != 5'd0);
         wr_reg_d  = b_reg;
         wr_data_d = b_data;
      end else begin
         wr_en_d   = 1'b0;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q  <= 4'd0;
         wr_en_q   <= 1'b0;
         wr_reg_q  <= 5'd0;
         wr_data_q <= '0;
      end else begin
         starve_q  <= starve_d;
         wr_en_q   <= wr_en_d;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign starve_cnt = starve_q;
   assign wr_en      = wr_en_q;
   assign wr_reg     = wr_reg_q;
   assign wr_data    = wr_data_q;

endmodule
